// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the switch/button input debouncer.
package input_debouncer_pkg;

    localparam int unsigned DEBOUNCE_10MS_100MHZ = 1_000_000;

    // Counter width able to hold 0..cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input: synchroniser, stability counter, debounced level and edge pulses.
module debounce_cell
    import input_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Counter only runs while the synchronised input disagrees with the held level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (s == level) begin
                cnt_q <= '0;
            end else if (cnt_q < CNT_LAST) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                level <= s;
                cnt_q <= '0;
                rise  <= s;
                fall  <= ~s;
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Synchronises and debounces the board slide switches and push button.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned N_SWT           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SWT-1:0] swt_raw,
    input  logic             btn_raw,
    output logic [N_SWT-1:0] swt_db,
    output logic             btn_db,
    output logic             btn_press,
    output logic             btn_release
);

    // Cells 0..N_SWT-1 are switches; the last cell is the button.
    for (genvar i = 0; i < N_SWT + 1; i++) begin : g_cell
        if (i < N_SWT) begin : g_swt
            logic unused_rise;
            logic unused_fall;
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_cell (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (swt_raw[i]),
                .level(swt_db[i]),
                .rise (unused_rise),
                .fall (unused_fall)
            );
        end else begin : g_btn
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_cell (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (btn_raw),
                .level(btn_db),
                .rise (btn_press),
                .fall (btn_release)
            );
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_input_debouncer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] swt_raw;
    logic       btn_raw;
    logic [3:0] swt_db;
    logic       btn_db;
    logic       btn_press;
    logic       btn_release;

    int n_checks = 0;
    int n_fail   = 0;

    input_debouncer #(
        .N_SWT          (4),
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .swt_raw    (swt_raw),
        .btn_raw    (btn_raw),
        .swt_db     (swt_db),
        .btn_db     (btn_db),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once the last D synchronised samples all agree on it.
    // s seen at edge k is the raw value captured at edge k-2, so hist[1..D] is the window.
    logic [4:0] hist [0:D];
    logic [4:0] m_db;
    logic       m_press;
    logic       m_rel;
    logic       same;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= D; i++) hist[i] = '0;
            m_db    = '0;
            m_press = 1'b0;
            m_rel   = 1'b0;
        end else begin
            m_press = 1'b0;
            m_rel   = 1'b0;
            for (int b = 0; b < 5; b++) begin
                same = 1'b1;
                for (int i = 2; i <= D; i++)
                    if (hist[i][b] != hist[1][b]) same = 1'b0;
                if (same && hist[1][b] != m_db[b]) begin
                    m_db[b] = hist[1][b];
                    if (b == 4) begin
                        m_press = hist[1][b];
                        m_rel   = ~hist[1][b];
                    end
                end
            end
            for (int i = D; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {btn_raw, swt_raw};
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input logic [3:0] swt, input logic btn);
        swt_raw = swt;
        btn_raw = btn;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if ({btn_db, swt_db, btn_press, btn_release} !== {m_db, m_press, m_rel}) begin
                n_fail++;
                $display("FAIL settle_model: got %b required %b",
                         {btn_db, swt_db, btn_press, btn_release}, {m_db, m_press, m_rel});
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        swt_raw = 4'hF;
        btn_raw = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({btn_db, swt_db, btn_press, btn_release} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b required 0000000",
                         {btn_db, swt_db, btn_press, btn_release});
            end
        end
        rst_n = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            n_checks++;
            if ({btn_db, swt_db} !== ((e >= 5) ? 5'h1F : 5'h00)) begin
                n_fail++;
                $display("FAIL reset_release_db edge %0d: got %h required %h",
                         e, {btn_db, swt_db}, (e >= 5) ? 5'h1F : 5'h00);
            end
            n_checks++;
            if (btn_press !== (e == 5)) begin
                n_fail++;
                $display("FAIL reset_release_press edge %0d: got %b required %b", e, btn_press, e == 5);
            end
        end
    endtask

    task automatic test_clean_press();
        settle(4'h0, 1'b0);
        btn_raw = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            n_checks++;
            if ({btn_db, btn_press} !== {1'(e >= 5), 1'(e == 5)}) begin
                n_fail++;
                $display("FAIL clean_press edge %0d: got db=%b press=%b required db=%b press=%b",
                         e, btn_db, btn_press, e >= 5, e == 5);
            end
        end
    endtask

    task automatic test_bounce();
        logic [9:0] pat;
        int presses;
        pat = 10'b11111_01101;
        presses = 0;
        settle(4'h0, 1'b0);
        for (int e = 0; e < 16; e++) begin
            btn_raw = (e < 10) ? pat[e] : 1'b1;
            tick();
            if (btn_press) presses++;
            n_checks++;
            if (btn_db !== (e >= 10)) begin
                n_fail++;
                $display("FAIL bounce_db edge %0d: got %b required %b", e, btn_db, e >= 10);
            end
        end
        n_checks++;
        if (presses != 1) begin
            n_fail++;
            $display("FAIL bounce_press_count: got %0d required 1", presses);
        end
    endtask

    task automatic test_glitch();
        settle(4'h0, 1'b1);
        for (int e = 0; e < 14; e++) begin
            swt_raw = (e < 3) ? 4'h4 : 4'h0;
            tick();
            n_checks++;
            if ({swt_db, btn_db, btn_press, btn_release} !== {4'h0, 1'b1, 2'b00}) begin
                n_fail++;
                $display("FAIL glitch edge %0d: got %b required 0000100", e,
                         {swt_db, btn_db, btn_press, btn_release});
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [6:0] exp;
        settle(4'h0, 1'b1);
        swt_raw = 4'hA;
        btn_raw = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (e < 5)       exp = {4'h0, 1'b1, 2'b00};
            else if (e == 5) exp = {4'hA, 1'b0, 2'b01};
            else             exp = {4'hA, 1'b0, 2'b00};
            n_checks++;
            if ({swt_db, btn_db, btn_press, btn_release} !== exp) begin
                n_fail++;
                $display("FAIL simultaneous edge %0d: got %b required %b", e,
                         {swt_db, btn_db, btn_press, btn_release}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        settle(4'hF, 1'b0);
        btn_raw = 1'b1;
        for (int e = 0; e <= 3; e++) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({btn_db, swt_db, btn_press, btn_release} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b required 0000000",
                     {btn_db, swt_db, btn_press, btn_release});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            n_checks++;
            if ({swt_db, btn_db, btn_press} !== {((e >= 5) ? 4'hF : 4'h0), 1'(e >= 5), 1'(e == 5)}) begin
                n_fail++;
                $display("FAIL reset_mid_requalify edge %0d: got %b required %b", e,
                         {swt_db, btn_db, btn_press},
                         {((e >= 5) ? 4'hF : 4'h0), 1'(e >= 5), 1'(e == 5)});
            end
        end
    endtask

    task automatic test_toggle();
        settle(4'h3, 1'b0);
        for (int e = 0; e < 40; e++) begin
            btn_raw = ~btn_raw;
            tick();
            n_checks++;
            if ({btn_db, btn_press, btn_release} !== 3'b000) begin
                n_fail++;
                $display("FAIL toggle edge %0d: got %b required 000", e, {btn_db, btn_press, btn_release});
            end
        end
    endtask

    task automatic test_random();
        logic prev_press, prev_rel;
        prev_press = 1'b0;
        prev_rel   = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) swt_raw[b] = ~swt_raw[b];
            if ($urandom_range(3) == 0) btn_raw = ~btn_raw;
            tick();
            n_checks++;
            if ({btn_db, swt_db, btn_press, btn_release} !== {m_db, m_press, m_rel}) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: got %b required %b", c,
                         {btn_db, swt_db, btn_press, btn_release}, {m_db, m_press, m_rel});
            end
            n_checks++;
            if ((btn_press && btn_release) || (btn_press && prev_press) || (btn_release && prev_rel)) begin
                n_fail++;
                $display("FAIL random_pulse_shape cycle %0d: got press=%b release=%b prev=%b%b required single non-overlapping pulses",
                         c, btn_press, btn_release, prev_press, prev_rel);
            end
            prev_press = btn_press;
            prev_rel   = btn_release;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        swt_raw = 4'h0;
        btn_raw = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
